trap_ctrl: RTL
==============

TRAP_CTRL -- requirements
Module: trap_ctrl

Interface
REQ-001 SHALL have: clk  input  1  clock; all state updates on rising edge.
REQ-002 SHALL have: rst  input  1  reset, synchronous, active-high.
REQ-003 SHALL have: instr_valid  input  1  upstream presents a system op; instr_ready  output  1  controller accepts.
REQ-004 SHALL have: op  input  3  0 CSRRW, 1 CSRRS, 2 CSRRC, 3 ECALL, 4 EBREAK, 5 MRET, 6-7 ILLEGAL.
REQ-005 SHALL have: csr_addr  input  12  target CSR; rs1_data  input  32  operand; pc  input  32  PC of op.
REQ-006 SHALL have: csr_addr_o  output  12, csr_wdata  output  32, csr_we  output  1  CSR file port; csr_rdata  input  32  combinational read of csr_addr_o.
REQ-007 SHALL have: rd_data  output  32, rd_we  output  1  GPR writeback (old CSR value).
REQ-008 SHALL have: redirect_valid  output  1, redirect_pc  output  32  next-PC override.
REQ-009 SHALL have: done  output  1  one-cycle completion pulse for the accepted op.

Function
REQ-010 SHALL accept an op only when instr_valid and instr_ready are both high; instr_ready SHALL be high only in IDLE; op, csr_addr, rs1_data, pc SHALL be latched at acceptance.
REQ-011 SHALL support CSRs mstatus 0x300, mtvec 0x305, mepc 0x341, mcause 0x342; a CSR op to any other address SHALL be handled as ILLEGAL.
REQ-012 CSR op states: IDLE -> C_RD (csr_addr_o=addr, capture csr_rdata) -> C_WR (csr_we, rd_we, rd_data=captured old, done) -> IDLE; done 2 cycles after acceptance.
REQ-013 C_WR wdata: CSRRW rs1; CSRRS old|rs1; CSRRC old&~rs1; CSRRS/CSRRC with rs1_data==0 SHALL suppress csr_we but still assert rd_we.
REQ-014 Trap (ECALL cause 11, EBREAK cause 3, ILLEGAL cause 2): IDLE -> T_EPC (we mepc=pc) -> T_CAUSE (we mcause=code) -> [T_SRD -> T_SWR] -> T_JMP -> IDLE.
REQ-015 T_SWR SHALL write mstatus with MPIE(bit7)=old MIE(bit3), MIE=0, MPP(bits12:11)=2'b11, other bits unchanged.
REQ-016 T_JMP SHALL drive csr_addr_o=0x305, redirect_valid=1, redirect_pc={csr_rdata[31:2],2'b00}, done=1 for one cycle; rd_we SHALL stay 0 for all traps.
REQ-017 MRET: IDLE -> [M_SRD -> M_SWR] -> M_JMP -> IDLE; M_SWR writes mstatus MIE=old MPIE, MPIE=1, MPP=2'b11; M_JMP redirects to mepc with done.
REQ-018 csr_we, rd_we, redirect_valid, done SHALL be single-cycle pulses, never asserted in IDLE; at most one CSR write per cycle.
REQ-019 Upstream input changes after acceptance SHALL NOT affect the op in flight.
REQ-020 Back-to-back ops: a new op SHALL be accepted no earlier than the cycle after done.

Reset
REQ-021 While rst is high, state SHALL be IDLE next edge and all outputs SHALL be 0 except instr_ready, which SHALL be 0 during rst and 1 in the first cycle after rst falls.
REQ-022 rst asserted mid-sequence SHALL abort the op: no further CSR writes, no done, no redirect.
REQ-023 Latched op/operand registers SHALL reset to 0.

Configuration
REQ-024 Macro TRAP_CTRL_MSTATUS_EN defined: bracketed states in REQ-014/REQ-017 present (trap 5 cycles, MRET 3 cycles accept-to-done).
REQ-025 Macro undefined: bracketed states omitted, mstatus never written by the controller (trap 3 cycles, MRET 1 cycle); CSR ops to mstatus unaffected.

Verification
REQ-026 CSRRW addr 0x305, rs1 0x80000100, mtvec=0 -> C_WR: csr_we, wdata 0x80000100, rd_data 0, done 2 cycles after accept.
REQ-027 CSRRS addr 0x342, rs1 0, mcause=0xB -> rd_data 0xB, rd_we=1, csr_we never asserted.
REQ-028 ECALL pc 0x80000040, mtvec 0x80000101, mstatus 0x1808 (macro on) -> mepc 0x80000040, mcause 11, mstatus 0x1880, redirect_pc 0x80000100, done at cycle 5.
REQ-029 MRET, mepc 0x80000044, mstatus 0x1880 (macro on) -> mstatus 0x1888, redirect_pc 0x80000044, done at cycle 3; macro off -> done at cycle 1, no mstatus write.
REQ-030 CSRRW addr 0x7C0 pc 0x80000010 -> trap cause 2, mepc 0x80000010, rd_we never asserted.
REQ-031 rst pulsed during T_CAUSE of an ECALL -> no mcause write, no redirect, instr_ready=1 first cycle after rst falls.

Source files
------------

// File: rtl/trap_ctrl.sv
// Machine-mode system-op sequencer: CSR read-modify-write, trap entry and MRET.
// Define TRAP_CTRL_MSTATUS_EN to add the mstatus save/restore states to trap and MRET.
module trap_ctrl (
   input  logic        clk,
   input  logic        rst,
   input  logic        instr_valid,
   output logic        instr_ready,
   input  logic [2:0]  op,
   input  logic [11:0] csr_addr,
   input  logic [31:0] rs1_data,
   input  logic [31:0] pc,
   output logic [11:0] csr_addr_o,
   output logic [31:0] csr_wdata,
   output logic        csr_we,
   input  logic [31:0] csr_rdata,
   output logic [31:0] rd_data,
   output logic        rd_we,
   output logic        redirect_valid,
   output logic [31:0] redirect_pc,
   output logic        done
);

   localparam logic [11:0] ADDR_MSTATUS = 12'h300;
   localparam logic [11:0] ADDR_MTVEC   = 12'h305;
   localparam logic [11:0] ADDR_MEPC    = 12'h341;
   localparam logic [11:0] ADDR_MCAUSE  = 12'h342;

   localparam logic [2:0] OP_CSRRW  = 3'd0;
   localparam logic [2:0] OP_CSRRS  = 3'd1;
   localparam logic [2:0] OP_CSRRC  = 3'd2;
   localparam logic [2:0] OP_ECALL  = 3'd3;
   localparam logic [2:0] OP_EBREAK = 3'd4;
   localparam logic [2:0] OP_MRET   = 3'd5;

   typedef enum logic [3:0] {
      IDLE, C_RD, C_WR,
      T_EPC, T_CAUSE, T_SRD, T_SWR, T_JMP,
      M_SRD, M_SWR, M_JMP
   } state_t;

   state_t      state, state_nxt;
   logic [2:0]  op_q;
   logic [11:0] addr_q;
   logic [31:0] rs1_q;
   logic [31:0] pc_q;
   logic [3:0]  cause_q;
   logic [31:0] old_q;

   logic       accept;
   logic       is_csr_op;
   logic       addr_ok;
   logic [3:0] cause_d;

   // Trap entry: MPIE <- MIE, MIE <- 0, MPP <- M.
   function automatic logic [31:0] trap_mstatus(input logic [31:0] s);
      return (s & ~32'h0000_1888) | {24'd0, s[3], 7'd0} | 32'h0000_1800;
   endfunction

   // Trap return: MIE <- MPIE, MPIE <- 1, MPP <- M.
   function automatic logic [31:0] mret_mstatus(input logic [31:0] s);
      return (s & ~32'h0000_1888) | {28'd0, s[7], 3'd0} | 32'h0000_1880;
   endfunction

   assign accept    = instr_valid && instr_ready;
   assign is_csr_op = (op == OP_CSRRW) || (op == OP_CSRRS) || (op == OP_CSRRC);
   assign addr_ok   = (csr_addr == ADDR_MSTATUS) || (csr_addr == ADDR_MTVEC) ||
                      (csr_addr == ADDR_MEPC)    || (csr_addr == ADDR_MCAUSE);
   assign cause_d   = (op == OP_ECALL) ? 4'd11 : (op == OP_EBREAK) ? 4'd3 : 4'd2;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of process ordering.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         op_q    <= '0;
         addr_q  <= '0;
         rs1_q   <= '0;
         pc_q    <= '0;
         cause_q <= '0;
         old_q   <= '0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            op_q    <= op;
            addr_q  <= csr_addr;
            rs1_q   <= rs1_data;
            pc_q    <= pc;
            cause_q <= cause_d;
         end
         if (state == C_RD || state == T_SRD || state == M_SRD)
            old_q <= csr_rdata;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (accept) begin
               if (is_csr_op && addr_ok)
                  state_nxt = C_RD;
               else if (op == OP_MRET)
`ifdef TRAP_CTRL_MSTATUS_EN
                  state_nxt = M_SRD;
`else
                  state_nxt = M_JMP;
`endif
               else
                  state_nxt = T_EPC;
            end
         end
         C_RD:    state_nxt = C_WR;
         C_WR:    state_nxt = IDLE;
         T_EPC:   state_nxt = T_CAUSE;
`ifdef TRAP_CTRL_MSTATUS_EN
         T_CAUSE: state_nxt = T_SRD;
`else
         T_CAUSE: state_nxt = T_JMP;
`endif
         T_SRD:   state_nxt = T_SWR;
         T_SWR:   state_nxt = T_JMP;
         T_JMP:   state_nxt = IDLE;
         M_SRD:   state_nxt = M_SWR;
         M_SWR:   state_nxt = M_JMP;
         M_JMP:   state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // NOTE: every output gets a default before the case so no latch is inferred.
   always_comb begin
      instr_ready    = (state == IDLE);
      csr_addr_o     = '0;
      csr_wdata      = '0;
      csr_we         = 1'b0;
      rd_data        = '0;
      rd_we          = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      done           = 1'b0;
      case (state)
         C_RD: csr_addr_o = addr_q;
         C_WR: begin
            csr_addr_o = addr_q;
            rd_data    = old_q;
            rd_we      = 1'b1;
            done       = 1'b1;
            csr_we     = (op_q == OP_CSRRW) || (rs1_q != '0);
            case (op_q)
               OP_CSRRS: csr_wdata = old_q | rs1_q;
               OP_CSRRC: csr_wdata = old_q & ~rs1_q;
               default:  csr_wdata = rs1_q;
            endcase
         end
         T_EPC: begin
            csr_addr_o = ADDR_MEPC;
            csr_wdata  = pc_q;
            csr_we     = 1'b1;
         end
         T_CAUSE: begin
            csr_addr_o = ADDR_MCAUSE;
            csr_wdata  = {28'd0, cause_q};
            csr_we     = 1'b1;
         end
         T_SRD, M_SRD: csr_addr_o = ADDR_MSTATUS;
         T_SWR: begin
            csr_addr_o = ADDR_MSTATUS;
            csr_wdata  = trap_mstatus(old_q);
            csr_we     = 1'b1;
         end
         M_SWR: begin
            csr_addr_o = ADDR_MSTATUS;
            csr_wdata  = mret_mstatus(old_q);
            csr_we     = 1'b1;
         end
         T_JMP: begin
            csr_addr_o     = ADDR_MTVEC;
            redirect_valid = 1'b1;
            redirect_pc    = {csr_rdata[31:2], 2'b00};
            done           = 1'b1;
         end
         M_JMP: begin
            csr_addr_o     = ADDR_MEPC;
            redirect_valid = 1'b1;
            redirect_pc    = csr_rdata;
            done           = 1'b1;
         end
         default: ;
      endcase
      // Reset silences every port in the same cycle, aborting any op in flight.
      if (rst) begin
         instr_ready    = 1'b0;
         csr_addr_o     = '0;
         csr_wdata      = '0;
         csr_we         = 1'b0;
         rd_data        = '0;
         rd_we          = 1'b0;
         redirect_valid = 1'b0;
         redirect_pc    = '0;
         done           = 1'b0;
      end
   end

endmodule
